// File: rtl/vga_timing_gen.sv
// Raster timing generator: programmable pixel divider, h/v counters and
// registered sync/blank/strobe outputs coherent with pixel_x/pixel_y.
module vga_timing_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 2,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISP);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISP);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISP + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_reg, div_next;
  logic [CW-1:0] h_reg, h_next;
  logic [CW-1:0] v_reg, v_next;
  logic [7:0]    frame_count_reg, frame_count_next;
  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;
  logic          video_on_reg, video_on_next;
  logic          line_start_reg, line_start_next;
  logic          frame_start_reg, frame_start_next;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;

  assign tick   = en && (div_reg == DIV_LAST);
  assign h_wrap = tick && (h_reg == H_LAST);
  assign v_wrap = h_wrap && (v_reg == V_LAST);

  always_comb begin
    div_next         = div_reg;
    h_next           = h_reg;
    v_next           = v_reg;
    frame_count_next = frame_count_reg;
    hsync_next       = hsync_reg;
    vsync_next       = vsync_reg;
    video_on_next    = video_on_reg;
    line_start_next  = h_wrap;
    frame_start_next = v_wrap;

    if (en) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
    end
    if (tick) begin
      h_next = h_wrap ? '0 : h_reg + CW'(1);
    end
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_reg + CW'(1);
    end
    if (v_wrap) begin
      frame_count_next = frame_count_reg + 8'd1;
    end

    // Decode from the next position so the flops line up with pixel_x/pixel_y.
    if (en) begin
      hsync_next    = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? HS_POL : ~HS_POL;
      vsync_next    = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? VS_POL : ~VS_POL;
      video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg         <= '0;
      h_reg           <= '0;
      v_reg           <= '0;
      frame_count_reg <= 8'd0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      video_on_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      h_reg           <= h_next;
      v_reg           <= v_next;
      frame_count_reg <= frame_count_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      video_on_reg    <= video_on_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  // The tick is gated by reset so it is quiet while the block is held.
  assign p_tick      = tick && !rst;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign pixel_x     = h_reg;
  assign pixel_y     = v_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule
